// File: rtl/sn_window_decoder_pkg.sv
// ----------------------------------------------------------------------------
// sn_pkg
// Shared definitions for the stochastic-number window decoder.
//   SN_MAX_LOG2 : default largest window exponent (window up to 2^8 bits)
//   sn_state_t  : decoder FSM states
//   clamp_log2  : maps a requested window exponent onto the supported range
//   bipolar     : 2*ones - 2^k as a 16-bit two's complement value
// ----------------------------------------------------------------------------
package sn_pkg;

   localparam int SN_MAX_LOG2 = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } sn_state_t;

   // A window of a single bit carries no bipolar information, so k=0 is
   // promoted to k=1. Anything beyond the counter range is pinned to the top.
   function automatic logic [3:0] clamp_log2(input logic [3:0] k,
                                             input int max_log2 = SN_MAX_LOG2);
      logic [3:0] k_eff;
      if (k == 4'd0)
         k_eff = 4'd1;
      else if (int'(k) > max_log2)
         k_eff = 4'(max_log2);
      else
         k_eff = k;
      return k_eff;
   endfunction

   // Computed wide enough that it never wraps for any supported window;
   // callers truncate to their result width.
   function automatic logic [15:0] bipolar(input logic [15:0] ones,
                                           input logic [3:0]  k);
      return (ones << 1) - (16'd1 << k);
   endfunction

endpackage

// File: rtl/sn_window_decoder_if.sv
// ----------------------------------------------------------------------------
// sn_window_decoder_if
// Stream-in / result-out bundle of the window decoder.
//   sn_bit, sn_valid   : stochastic bitstream, one bit per valid cycle
//   win_log2           : requested window exponent
//   clear              : synchronous restart
//   res_ones           : ones counted in the last completed window
//   res_bipolar        : signed 2*res_ones - L
//   res_valid/res_ready: result handshake
//   overrun            : sticky, an unconsumed result was overwritten
//   busy               : decoder is inside a window
// Modports: slave = decoder side, master = stream source / result consumer.
// ----------------------------------------------------------------------------
interface sn_window_decoder_if #(
   parameter int MAX_LOG2 = 8,
   parameter int CNT_W    = MAX_LOG2 + 1
);
   logic             sn_bit;
   logic             sn_valid;
   logic [3:0]       win_log2;
   logic             clear;
   logic [CNT_W-1:0] res_ones;
   logic [CNT_W:0]   res_bipolar;
   logic             res_valid;
   logic             res_ready;
   logic             overrun;
   logic             busy;

   modport slave (
      input  sn_bit, sn_valid, win_log2, clear, res_ready,
      output res_ones, res_bipolar, res_valid, overrun, busy
   );

   modport master (
      output sn_bit, sn_valid, win_log2, clear, res_ready,
      input  res_ones, res_bipolar, res_valid, overrun, busy
   );
endinterface

// File: rtl/sn_window_decoder_result_reg.sv
// ----------------------------------------------------------------------------
// sn_result_reg
// Output holding register of the window decoder with valid/ready handshake.
//   clk, rst_n         : clock, async active-high reset
//   clear              : synchronous restart (drops valid and overrun, keeps data)
//   load               : a window completed this cycle
//   load_ones          : ones count of the completed window
//   load_bipolar       : bipolar value of the completed window
//   res_ready          : consumer accepts the held result
//   res_ones           : held ones count
//   res_bipolar        : held bipolar value
//   res_valid          : result held and available
//   overrun            : sticky, a held result was overwritten unconsumed
// ----------------------------------------------------------------------------
module sn_result_reg #(
   parameter int CNT_W = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_ones,
   input  logic [CNT_W:0]   load_bipolar,
   input  logic             res_ready,
   output logic [CNT_W-1:0] res_ones,
   output logic [CNT_W:0]   res_bipolar,
   output logic             res_valid,
   output logic             overrun
);

   logic [CNT_W-1:0] ones_reg;
   logic [CNT_W:0]   bipolar_reg;
   logic             valid_reg;
   logic             overrun_reg;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         ones_reg    <= '0;
         bipolar_reg <= '0;
         valid_reg   <= 1'b0;
         overrun_reg <= 1'b0;
      end else if (clear) begin
         // Data is deliberately kept so the last result stays readable.
         valid_reg   <= 1'b0;
         overrun_reg <= 1'b0;
      end else if (load) begin
         ones_reg    <= load_ones;
         bipolar_reg <= load_bipolar;
         valid_reg   <= 1'b1;
         // Overwriting is only an overrun if the old value is not being
         // taken on this very edge.
         if (valid_reg && !res_ready)
            overrun_reg <= 1'b1;
      end else if (valid_reg && res_ready) begin
         valid_reg <= 1'b0;
      end
   end

   assign res_ones    = ones_reg;
   assign res_bipolar = bipolar_reg;
   assign res_valid   = valid_reg;
   assign overrun     = overrun_reg;

endmodule

// File: rtl/sn_window_decoder.sv
// ----------------------------------------------------------------------------
// sn_window_decoder
// Counts ones of a serial stochastic bitstream over back-to-back windows of
// 2^k valid bits and presents the ones count and the bipolar value
// 2*ones - 2^k through a valid/ready result register.
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active HIGH (asserted = 1)
//   bus   : sn_window_decoder_if slave modport (stream in, results out)
// ----------------------------------------------------------------------------
module sn_window_decoder
   import sn_pkg::*;
#(
   parameter int MAX_LOG2 = SN_MAX_LOG2,
   parameter int CNT_W    = MAX_LOG2 + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sn_window_decoder_if.slave   bus
);

   localparam int BIP_W = CNT_W + 1;

   sn_state_t        state_reg, state_next;
   logic [CNT_W-1:0] ones_reg,  ones_next;
   logic [CNT_W-1:0] bits_reg,  bits_next;
   logic [3:0]       k_reg,     k_next;

   logic             sn_bit;
   logic             sn_valid;
   logic             clear;
   logic [3:0]       k_req_eff;
   logic [CNT_W-1:0] ones_plus;
   logic [CNT_W-1:0] window_last;
   logic             load_res;
   logic [CNT_W-1:0] load_ones;
   logic [BIP_W-1:0] load_bipolar;

   logic [CNT_W-1:0] res_ones;
   logic [BIP_W-1:0] res_bipolar;
   logic             res_valid;
   logic             overrun;

   assign sn_bit    = bus.sn_bit;
   assign sn_valid  = bus.sn_valid;
   assign clear     = bus.clear;
   assign k_req_eff = clamp_log2(bus.win_log2, MAX_LOG2);

   // Count including the bit on the input this cycle; this is what a
   // completing window reports.
   assign ones_plus   = ones_reg + CNT_W'(sn_bit);
   // Index of the final bit of the current window (L-1). L = 2^MAX_LOG2
   // still fits in CNT_W bits.
   assign window_last = (CNT_W'(1) << k_reg) - CNT_W'(1);

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_reg <= IDLE;
         ones_reg  <= '0;
         bits_reg  <= '0;
         k_reg     <= 4'd1;
      end else begin
         state_reg <= state_next;
         ones_reg  <= ones_next;
         bits_reg  <= bits_next;
         k_reg     <= k_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      ones_next    = ones_reg;
      bits_next    = bits_reg;
      k_next       = k_reg;
      load_res     = 1'b0;
      load_ones    = ones_plus;
      load_bipolar = BIP_W'(bipolar(16'(ones_plus), k_reg));

      if (clear) begin
         state_next = IDLE;
         ones_next  = '0;
         bits_next  = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               // The first valid bit both fixes the window size and is
               // counted as bit 0. The minimum window is 2, so it can
               // never complete a window by itself.
               if (sn_valid) begin
                  k_next     = k_req_eff;
                  ones_next  = CNT_W'(sn_bit);
                  bits_next  = CNT_W'(1);
                  state_next = ACCUM;
               end
            end
            ACCUM: begin
               if (sn_valid) begin
                  if (bits_reg == window_last) begin
                     // Window done: report it and start the next window on
                     // the same edge so no stream bit is lost.
                     load_res  = 1'b1;
                     ones_next = '0;
                     bits_next = '0;
                     k_next    = k_req_eff;
                  end else begin
                     ones_next = ones_plus;
                     bits_next = bits_reg + CNT_W'(1);
                  end
               end
            end
            default: begin
               state_next = IDLE;
               ones_next  = '0;
               bits_next  = '0;
            end
         endcase
      end
   end

   sn_result_reg #(
      .CNT_W (CNT_W)
   ) u_result_reg (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear),
      .load         (load_res),
      .load_ones    (load_ones),
      .load_bipolar (load_bipolar),
      .res_ready    (bus.res_ready),
      .res_ones     (res_ones),
      .res_bipolar  (res_bipolar),
      .res_valid    (res_valid),
      .overrun      (overrun)
   );

   assign bus.res_ones    = res_ones;
   assign bus.res_bipolar = res_bipolar;
   assign bus.res_valid   = res_valid;
   assign bus.overrun     = overrun;
   assign bus.busy        = (state_reg == ACCUM);

endmodule

// File: tb/tb_sn_window_decoder.sv
// ----------------------------------------------------------------------------
// tb_sn_window_decoder
// Directed stimulus with hand-computed expectations. Expected results are
// queued when a window is sent; a monitor pops and compares every result the
// decoder hands over (res_valid && res_ready). Status signals (valid timing,
// overrun, busy, reset/clear effects) are checked inline.
// ----------------------------------------------------------------------------
module tb_sn_window_decoder;

   localparam int MAX_LOG2 = 8;
   localparam int CNT_W    = MAX_LOG2 + 1;

   typedef struct packed {
      logic [CNT_W-1:0] ones;
      logic [CNT_W:0]   bip;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   sn_window_decoder_if #(.MAX_LOG2(MAX_LOG2)) bus ();

   sn_window_decoder #(.MAX_LOG2(MAX_LOG2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic expect_res(input int ones, input int bip);
      exp_t e;
      e.ones = CNT_W'(ones);
      e.bip  = (CNT_W+1)'(bip);
      exp_q.push_back(e);
   endtask

   // Compares every handed-over result against the oldest queued expectation.
   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n && bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_result: got ones=%0d bipolar=%0d, expected none",
                        bus.res_ones, $signed(bus.res_bipolar));
            end else begin
               e = exp_q.pop_front();
               $display("result: ones=%0d bipolar=%0d (expected %0d / %0d)",
                        bus.res_ones, $signed(bus.res_bipolar), e.ones, $signed(e.bip));
               chk("res_ones", int'(bus.res_ones), int'(e.ones));
               chk("res_bipolar", int'($signed(bus.res_bipolar)), int'($signed(e.bip)));
            end
         end
      end
   endtask

   task automatic step(input logic b, input logic v);
      bus.sn_bit   = b;
      bus.sn_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   task automatic do_clear();
      bus.clear    = 1'b1;
      bus.sn_valid = 1'b0;
      @(posedge clk);
      #1;
      bus.clear = 1'b0;
   endtask

   // Bounded wait for the monitor to consume all queued expectations.
   task automatic drain();
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1'b0, 1'b0);
      chk("drained", exp_q.size(), 0);
   endtask

   initial begin
      bus.sn_bit    = 1'b0;
      bus.sn_valid  = 1'b0;
      bus.win_log2  = 4'd3;
      bus.clear     = 1'b0;
      bus.res_ready = 1'b1;

      fork
         monitor();
      join_none

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_res_ones", int'(bus.res_ones), 0);
      chk("rst_res_bipolar", int'(bus.res_bipolar), 0);
      chk("rst_res_valid", int'(bus.res_valid), 0);
      chk("rst_overrun", int'(bus.overrun), 0);
      chk("rst_busy", int'(bus.busy), 0);
      rst_n = 1'b0;
      idle(2);

      // k=3, eight ones -> 8 / +8, valid one cycle after the 8th bit
      bus.win_log2 = 4'd3;
      expect_res(8, 8);
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
      chk("t1_busy", int'(bus.busy), 1);
      chk("t1_valid_before_last", int'(bus.res_valid), 0);
      step(1'b1, 1'b1);
      chk("t1_valid_after_last", int'(bus.res_valid), 1);
      drain();

      // k=3, 1,0,1,0,... with invalid (sn_bit=1) cycles in between -> 4 / 0
      do_clear();
      expect_res(4, 0);
      for (int i = 0; i < 8; i++) begin
         step((i % 2) == 0, 1'b1);
         step(1'b1, 1'b0);
      end
      drain();

      // k=4, 16 zeros then 16 ones back-to-back
      do_clear();
      bus.win_log2 = 4'd4;
      expect_res(0, -16);
      expect_res(16, 16);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b1, 1'b1);
      drain();

      // Overrun: k=1, ready low across "11" then "01"
      do_clear();
      bus.res_ready = 1'b0;
      bus.win_log2  = 4'd1;
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      chk("ovr_first_valid", int'(bus.res_valid), 1);
      chk("ovr_first_ones", int'(bus.res_ones), 2);
      chk("ovr_first_overrun", int'(bus.overrun), 0);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      chk("ovr_second_ones", int'(bus.res_ones), 1);
      chk("ovr_second_bipolar", int'($signed(bus.res_bipolar)), 0);
      chk("ovr_second_valid", int'(bus.res_valid), 1);
      chk("ovr_set", int'(bus.overrun), 1);
      idle(2);
      chk("ovr_sticky", int'(bus.overrun), 1);
      chk("ovr_hold_ones", int'(bus.res_ones), 1);
      do_clear();
      chk("clr_valid", int'(bus.res_valid), 0);
      chk("clr_overrun", int'(bus.overrun), 0);
      chk("clr_keeps_ones", int'(bus.res_ones), 1);
      chk("clr_busy", int'(bus.busy), 0);

      // Completion while the held result is transferring: no overrun
      expect_res(1, 0);
      expect_res(2, 2);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      bus.res_ready = 1'b1;
      step(1'b1, 1'b1);
      chk("simul_valid", int'(bus.res_valid), 1);
      chk("simul_overrun", int'(bus.overrun), 0);
      drain();

      // win_log2=0 -> window of 2
      do_clear();
      bus.win_log2 = 4'd0;
      expect_res(2, 2);
      step(1'b1, 1'b1);
      chk("k0_valid_after_1", int'(bus.res_valid), 0);
      step(1'b1, 1'b1);
      chk("k0_valid_after_2", int'(bus.res_valid), 1);
      drain();

      // win_log2=12 -> window of 256, every 4th bit set -> 64 / -128
      do_clear();
      bus.win_log2 = 4'd12;
      expect_res(64, -128);
      for (int i = 0; i < 255; i++) step((i % 4) == 0, 1'b1);
      chk("k12_valid_after_255", int'(bus.res_valid), 0);
      step(1'b0, 1'b1);
      chk("k12_valid_after_256", int'(bus.res_valid), 1);
      drain();

      // win_log2 3 -> 2 after bit 4: 8-bit window, then 4-bit window
      do_clear();
      bus.win_log2 = 4'd3;
      expect_res(4, 0);
      expect_res(3, 2);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
      bus.win_log2 = 4'd2;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
      chk("kchg_valid_after_7", int'(bus.res_valid), 0);
      step(1'b0, 1'b1);
      chk("kchg_valid_after_8", int'(bus.res_valid), 1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      drain();

      // Async reset after 5 bits of an 8-bit window
      do_clear();
      bus.win_log2 = 4'd3;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
      chk("pre_rst_busy", int'(bus.busy), 1);
      #2;
      rst_n = 1'b1;
      #1;
      chk("async_rst_ones", int'(bus.res_ones), 0);
      chk("async_rst_bipolar", int'(bus.res_bipolar), 0);
      chk("async_rst_valid", int'(bus.res_valid), 0);
      chk("async_rst_overrun", int'(bus.overrun), 0);
      chk("async_rst_busy", int'(bus.busy), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      expect_res(5, 2);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
